// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
//   slave  : view taken by load_store_unit (requests and mem_rdata in,
//            stall/response/error/memory controls out)
//   master : view taken by the pipeline/memory side driving the unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err_misalign;
    logic        err_oob;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_op, req_addr, req_wdata, mem_rdata,
        output stall, resp_valid, resp_data, err_misalign, err_oob,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_store, req_op, req_addr, req_wdata, mem_rdata,
        input  stall, resp_valid, resp_data, err_misalign, err_oob,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the EX stage and a single-port word memory with
// combinational read data.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (also gates mem_read/mem_write)
//   bus   : load_store_unit_if.slave
//           req_valid/req_store/req_op/req_addr/req_wdata : request
//           stall                    : high while a sub-word store writes back
//           resp_valid/resp_data     : load result, one cycle after accept
//           err_misalign/err_oob     : one-cycle error pulses after accept
//           mem_addr/mem_wdata/mem_read/mem_write/mem_rdata : memory port
// Loads and word stores take one cycle. Byte/halfword stores read the word,
// merge the new lane, and write it back in a second (stalled) cycle.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] merge_r;
    logic [31:0] addr_r;
    logic        resp_valid_r;
    logic [31:0] resp_data_r;
    logic        err_misalign_r;
    logic        err_oob_r;

    logic        accept_s;
    logic        legal_s;
    logic        misalign_s;
    logic        oob_s;
    logic        go_s;
    logic        is_word_s;
    logic [31:0] load_ext_s;
    logic [31:0] merged_s;

    // Sign/zero extension of the addressed byte or halfword; op[1:0] picks
    // the size, op[2] selects zero extension.
    function automatic logic [31:0] load_extend(input logic [2:0] op,
                                                input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    // Place the low byte/halfword of wdata into the addressed lane of word.
    function automatic logic [31:0] store_merge(input logic [1:0] sz,
                                                input logic [1:0] lo,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        case (sz)
            2'b00: begin
                case (lo)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res = word;
                endcase
            end
            2'b01: begin
                if (lo[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Request decode: legality, alignment, range and memory port drive.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && bus.req_valid;
        is_word_s  = (bus.req_op[1:0] == 2'b10);
        legal_s    = 1'b0;
        misalign_s = 1'b0;
        if (bus.req_store) begin
            legal_s = (bus.req_op[1:0] != 2'b11);
        end else begin
            case (bus.req_op)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end
        case (bus.req_op[1:0])
            2'b10:   misalign_s = (bus.req_addr[1:0] != 2'b00);
            2'b01:   misalign_s = bus.req_addr[0];
            default: misalign_s = 1'b0;
        endcase
        // Illegal encodings never raise errors.
        misalign_s = misalign_s && legal_s;
        oob_s      = legal_s && (bus.req_addr >= MEM_BYTES);
        go_s       = accept_s && legal_s && !misalign_s && !oob_s;

        load_ext_s = load_extend(bus.req_op, bus.req_addr[1:0], bus.mem_rdata);
        merged_s   = store_merge(bus.req_op[1:0], bus.req_addr[1:0],
                                 bus.mem_rdata, bus.req_wdata);

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = {bus.req_addr[31:2], 2'b00};
        bus.mem_wdata = bus.req_wdata;
        if (state_r == ST_RMW_WRITE) begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = addr_r;
            bus.mem_wdata = merge_r;
        end else if (go_s) begin
            // Word stores write directly; loads and sub-word stores read.
            bus.mem_read  = !(bus.req_store && is_word_s);
            bus.mem_write = bus.req_store && is_word_s;
        end else begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
        // Reset blocks any memory access immediately, aborting a pending RMW.
        if (!rst_n) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end else begin
            bus.mem_read  = bus.mem_read;
            bus.mem_write = bus.mem_write;
        end
    end

    // State machine, merge/address capture and registered response/errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            merge_r        <= 32'h00000000;
            addr_r         <= 32'h00000000;
            resp_valid_r   <= 1'b0;
            resp_data_r    <= 32'h00000000;
            err_misalign_r <= 1'b0;
            err_oob_r      <= 1'b0;
        end else begin
            resp_valid_r   <= go_s && !bus.req_store;
            err_misalign_r <= accept_s && misalign_s;
            err_oob_r      <= accept_s && oob_s;
            if (go_s && !bus.req_store) begin
                resp_data_r <= load_ext_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (go_s && bus.req_store && !is_word_s) begin
                        merge_r <= merged_s;
                        addr_r  <= {bus.req_addr[31:2], 2'b00};
                        state_r <= ST_RMW_WRITE;
                    end
                end
                ST_RMW_WRITE: state_r <= ST_IDLE;
                default:      state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall        = (state_r == ST_RMW_WRITE);
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_data    = resp_data_r;
    assign bus.err_misalign = err_misalign_r;
    assign bus.err_oob      = err_oob_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1: EX-stage memory request present.
REQ-005 SHALL have port req_store  input  1: 1 = store, 0 = load.
REQ-006 SHALL have port req_op  input  3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use req_op[1:0]: 00 SB, 01 SH, 10 SW.
REQ-007 SHALL have port req_addr  input  32: byte address.
REQ-008 SHALL have port req_wdata  input  32: store data; the sub-word value is in the low bits.
REQ-009 SHALL have port stall  output  1: upstream holds its request while high.
REQ-010 SHALL have port resp_valid  output  1: load result valid.
REQ-011 SHALL have port resp_data  output  32: extended load result.
REQ-012 SHALL have port err_misalign  output  1: one-cycle pulse on a misaligned access.
REQ-013 SHALL have port err_oob  output  1: one-cycle pulse when the address is at or above 4*MEM_WORDS.
REQ-014 SHALL have port mem_addr  output  32: word-aligned address to memory (low 2 bits zero).
REQ-015 SHALL have port mem_wdata  output  32: write data to memory.
REQ-016 SHALL have port mem_read  output  1: memory read enable.
REQ-017 SHALL have port mem_write  output  1: memory write enable; memory commits on the next rising edge.
REQ-018 SHALL have port mem_rdata  input  32: combinational memory read data.

Function
REQ-019 SHALL implement two states: IDLE and RMW_WRITE; stall SHALL be 1 exactly in RMW_WRITE.
REQ-020 SHALL accept a request only in IDLE with req_valid=1; in RMW_WRITE, req_* SHALL be ignored.
REQ-021 SHALL use little-endian byte lanes: byte at addr[1:0]=n occupies bits [8n+7:8n]; halfword at addr[1]=h occupies bits [16h+15:16h].
REQ-022 SHALL treat these as misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
REQ-023 On a misaligned or out-of-range request, SHALL perform no memory access and produce no resp_valid; SHALL pulse the matching error flag the next cycle. Both flags may pulse together.
REQ-024 SHALL ignore illegal encodings (load op 011/110/111, store op[1:0]=11): no access, no response, no error.
REQ-025 Load: in the accept cycle, SHALL drive mem_read=1 and mem_addr={addr[31:2],00}.
REQ-026 Load: on the next edge, SHALL register resp_data and set resp_valid=1 for exactly one cycle (latency 1).
REQ-027 Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-028 SW: SHALL drive mem_write=1 and mem_wdata=req_wdata in the accept cycle; no stall.
REQ-029 SB/SH accept cycle: SHALL drive mem_read=1, merge req_wdata[7:0]/[15:0] into the selected lane of mem_rdata, and register the merged word and the address.
REQ-030 SB/SH: SHALL then enter RMW_WRITE.
REQ-031 RMW_WRITE: SHALL drive mem_write=1 with the registered word and address, then return to IDLE.
REQ-032 Outside the cases in REQ-025 to REQ-031, SHALL hold mem_read=0 and mem_write=0.
REQ-033 resp_valid, err_misalign and err_oob SHALL be 0 in any cycle not following an accept that sets them.

Reset
REQ-034 While rst_n=0, SHALL force mem_read=0 and mem_write=0 combinationally.
REQ-035 With rst_n=0 at an edge, SHALL set state=IDLE, resp_valid=0, resp_data=0, err_misalign=0, err_oob=0, and clear the merge and address registers.
REQ-036 Reset asserted during RMW_WRITE SHALL abort the write: memory is unchanged and the state after reset is IDLE.

Verification
REQ-037 Word 0x10 = 0x8899AABB; LB at 0x11 -> one cycle later resp_valid=1, resp_data=0xFFFFFFAA; LBU at 0x11 -> 0x000000AA.
REQ-038 Word 0x10 = 0x8899AABB; SH of 0x1234 at 0x12 -> stall=1 for one cycle, one mem_write; word 0x10 becomes 0x1234AABB.
REQ-039 Back-to-back SW 0xDEADBEEF to 0x20, then LW 0x20 -> no stall; resp_data=0xDEADBEEF one cycle after the LW.
REQ-040 LW at 0x22 -> err_misalign pulses, resp_valid=0, no mem_read. SW at 0x100 with MEM_WORDS=64 -> err_oob pulses, memory unchanged.
REQ-041 SB 0x55 to 0x30 (word 0x30 = 0), with rst_n=0 during RMW_WRITE -> word 0x30 stays 0; stall=0 and state is IDLE after reset.
REQ-042 Request with req_valid held high during RMW_WRITE -> that request is not accepted until stall drops; exactly one access per accepted request.
